fsk_demod_corr: RTL and testbench

Parametrised non-coherent binary FSK demodulator, successor to the fixed `demodulation` block. It takes a valid-qualified signed sample stream and correlates each symbol against two square-wave reference tones, in phase (I) and quadrature (Q). Tone frequencies and symbol length are generated internally by phase accumulators. At each symbol boundary it decides the bit by comparing tone energies, and it exports both energy metrics for threshold and lock logic downstream.

---
 rtl/fsk_demod_corr.sv | 208 ++++++++++++++++++++
 tb/tb_fsk_demod_corr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_demod_corr.sv
// fsk_demod_corr: non-coherent binary FSK demodulator.
// Each symbol is correlated against square-wave I/Q references for two tones.
// The tone phases and the symbol length come from internal accumulators.
// At the symbol boundary the bit is decided by comparing the two energy metrics.
module fsk_demod_corr #(
    parameter  int DATA_W  = 11,
    parameter  int SYM_LEN = 800,
    parameter  int PHASE_W = 16,
    parameter  int INC_F1  = 655,
    parameter  int INC_F2  = 1311,
    localparam int ACC_W   = DATA_W + $clog2(SYM_LEN) + 1,
    localparam int MET_W   = ACC_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              sym_start,
    output logic              bit_out,
    output logic              bit_valid,
    output logic [MET_W-1:0]  metric_f1,
    output logic [MET_W-1:0]  metric_f2
);

    localparam int CNT_W = $clog2(SYM_LEN);

    localparam logic [PHASE_W-1:0] PH_INC1  = PHASE_W'(INC_F1);
    localparam logic [PHASE_W-1:0] PH_INC2  = PHASE_W'(INC_F2);
    localparam logic [PHASE_W-1:0] PH_ZERO  = {PHASE_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SYM_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ACC_W-1:0]   ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [MET_W-1:0]   MET_ZERO = {MET_W{1'b0}};

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_DECIDE = 1'b1
    } state_t;

    // Magnitude of a signed accumulator, widened by one bit so that the most
    // negative value still has a representable magnitude.
    function automatic logic [MET_W-1:0] abs_ext(input logic [ACC_W-1:0] a);
        logic [MET_W-1:0] ext;
        ext = {a[ACC_W-1], a};
        if (a[ACC_W-1]) begin
            abs_ext = (~ext) + {{(MET_W-1){1'b0}}, 1'b1};
        end else begin
            abs_ext = ext;
        end
    endfunction

    // One correlation step: the reference is +/-1, so multiply becomes add or subtract.
    function automatic logic [ACC_W-1:0] corr_step(input logic [ACC_W-1:0] base,
                                                   input logic [ACC_W-1:0] x,
                                                   input logic             neg);
        if (neg) begin
            corr_step = base - x;
        end else begin
            corr_step = base + x;
        end
    endfunction

    state_t             r_state;
    logic               r_in_ready;
    logic [PHASE_W-1:0] r_ph1;
    logic [PHASE_W-1:0] r_ph2;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc_i1;
    logic [ACC_W-1:0]   r_acc_q1;
    logic [ACC_W-1:0]   r_acc_i2;
    logic [ACC_W-1:0]   r_acc_q2;
    logic [MET_W-1:0]   r_metric_f1;
    logic [MET_W-1:0]   r_metric_f2;
    logic               r_bit_out;
    logic               r_bit_valid;

    logic               w_accept;
    logic [ACC_W-1:0]   w_x_ext;
    logic [PHASE_W-1:0] w_ph1_cur;
    logic [PHASE_W-1:0] w_ph2_cur;
    logic [CNT_W-1:0]   w_cnt_base;
    logic [ACC_W-1:0]   w_acc_i1_nxt;
    logic [ACC_W-1:0]   w_acc_q1_nxt;
    logic [ACC_W-1:0]   w_acc_i2_nxt;
    logic [ACC_W-1:0]   w_acc_q2_nxt;
    logic [MET_W-1:0]   w_metric_f1;
    logic [MET_W-1:0]   w_metric_f2;

    // Accept path: a resync strobe restarts the symbol, so the sample taken in
    // that cycle correlates against phase 0 and empty accumulators.
    always_comb begin
        w_accept = in_valid & r_in_ready;
        w_x_ext  = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
        if (sym_start) begin
            w_ph1_cur    = PH_ZERO;
            w_ph2_cur    = PH_ZERO;
            w_cnt_base   = CNT_ZERO;
            w_acc_i1_nxt = corr_step(ACC_ZERO, w_x_ext, 1'b0);
            w_acc_q1_nxt = corr_step(ACC_ZERO, w_x_ext, 1'b0);
            w_acc_i2_nxt = corr_step(ACC_ZERO, w_x_ext, 1'b0);
            w_acc_q2_nxt = corr_step(ACC_ZERO, w_x_ext, 1'b0);
        end else begin
            w_ph1_cur    = r_ph1;
            w_ph2_cur    = r_ph2;
            w_cnt_base   = r_cnt;
            w_acc_i1_nxt = corr_step(r_acc_i1, w_x_ext, r_ph1[PHASE_W-1]);
            w_acc_q1_nxt = corr_step(r_acc_q1, w_x_ext, r_ph1[PHASE_W-1] ^ r_ph1[PHASE_W-2]);
            w_acc_i2_nxt = corr_step(r_acc_i2, w_x_ext, r_ph2[PHASE_W-1]);
            w_acc_q2_nxt = corr_step(r_acc_q2, w_x_ext, r_ph2[PHASE_W-1] ^ r_ph2[PHASE_W-2]);
        end
    end

    // Tone energies from the finished symbol's accumulators.
    always_comb begin
        w_metric_f1 = abs_ext(r_acc_i1) + abs_ext(r_acc_q1);
        w_metric_f2 = abs_ext(r_acc_i2) + abs_ext(r_acc_q2);
    end

    // Control FSM with correlation datapath and registered decision outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b0;
            r_ph1       <= PH_ZERO;
            r_ph2       <= PH_ZERO;
            r_cnt       <= CNT_ZERO;
            r_acc_i1    <= ACC_ZERO;
            r_acc_q1    <= ACC_ZERO;
            r_acc_i2    <= ACC_ZERO;
            r_acc_q2    <= ACC_ZERO;
            r_metric_f1 <= MET_ZERO;
            r_metric_f2 <= MET_ZERO;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc_i1 <= w_acc_i1_nxt;
                        r_acc_q1 <= w_acc_q1_nxt;
                        r_acc_i2 <= w_acc_i2_nxt;
                        r_acc_q2 <= w_acc_q2_nxt;
                        r_ph1    <= w_ph1_cur + PH_INC1;
                        r_ph2    <= w_ph2_cur + PH_INC2;
                        if (w_cnt_base == CNT_LAST) begin
                            r_cnt      <= CNT_ZERO;
                            r_state    <= ST_DECIDE;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else if (sym_start) begin
                        r_acc_i1 <= ACC_ZERO;
                        r_acc_q1 <= ACC_ZERO;
                        r_acc_i2 <= ACC_ZERO;
                        r_acc_q2 <= ACC_ZERO;
                        r_ph1    <= PH_ZERO;
                        r_ph2    <= PH_ZERO;
                        r_cnt    <= CNT_ZERO;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                ST_DECIDE: begin
                    // A resync here drops the decision; outputs keep their old values.
                    if (!sym_start) begin
                        r_metric_f1 <= w_metric_f1;
                        r_metric_f2 <= w_metric_f2;
                        r_bit_out   <= (w_metric_f2 > w_metric_f1);
                        r_bit_valid <= 1'b1;
                    end else begin
                        r_bit_valid <= 1'b0;
                    end
                    r_acc_i1   <= ACC_ZERO;
                    r_acc_q1   <= ACC_ZERO;
                    r_acc_i2   <= ACC_ZERO;
                    r_acc_q2   <= ACC_ZERO;
                    r_ph1      <= PH_ZERO;
                    r_ph2      <= PH_ZERO;
                    r_cnt      <= CNT_ZERO;
                    r_state    <= ST_ACCUM;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_acc_i1   <= ACC_ZERO;
                    r_acc_q1   <= ACC_ZERO;
                    r_acc_i2   <= ACC_ZERO;
                    r_acc_q2   <= ACC_ZERO;
                    r_ph1      <= PH_ZERO;
                    r_ph2      <= PH_ZERO;
                    r_cnt      <= CNT_ZERO;
                    r_state    <= ST_ACCUM;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign metric_f1 = r_metric_f1;
    assign metric_f2 = r_metric_f2;

endmodule

// File: tb/tb_fsk_demod_corr.sv
// Self-checking bench for fsk_demod_corr in the small test configuration.
module tb_fsk_demod_corr;

    localparam int DATA_W  = 11;
    localparam int SYM_LEN = 8;
    localparam int PHASE_W = 4;
    localparam int INC_F1  = 2;
    localparam int INC_F2  = 4;
    localparam int MET_W   = DATA_W + $clog2(SYM_LEN) + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              sym_start = 1'b0;
    logic              bit_out;
    logic              bit_valid;
    logic [MET_W-1:0]  metric_f1;
    logic [MET_W-1:0]  metric_f2;

    int errors = 0;
    int checks = 0;
    int bv_count = 0;
    int sym [SYM_LEN];
    int prev_m1 = 0;
    int prev_m2 = 0;
    int prev_bit = 0;

    fsk_demod_corr #(
        .DATA_W (DATA_W),
        .SYM_LEN(SYM_LEN),
        .PHASE_W(PHASE_W),
        .INC_F1 (INC_F1),
        .INC_F2 (INC_F2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sym_start(sym_start),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .metric_f1(metric_f1),
        .metric_f2(metric_f2)
    );

    always #5 clk = ~clk;

    // Count every decision pulse seen on a rising edge.
    always @(posedge clk) begin
        if (bit_valid === 1'b1) bv_count <= bv_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference correlation: square tones derived from the phase quadrant.
    function automatic int model(input int inc);
        int si = 0;
        int sq = 0;
        int ph;
        int ri;
        int rq;
        for (int k = 0; k < SYM_LEN; k++) begin
            ph = (k * inc) % (1 << PHASE_W);
            ri = (ph < (1 << (PHASE_W - 1))) ? 1 : -1;
            rq = (ph < (1 << (PHASE_W - 2)) || ph >= 3 * (1 << (PHASE_W - 2))) ? 1 : -1;
            si += ri * sym[k];
            sq += rq * sym[k];
        end
        return ((si < 0) ? -si : si) + ((sq < 0) ? -sq : sq);
    endfunction

    task automatic send_one(input int x, input bit gap);
        int guard;
        if (gap) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data  = DATA_W'(x);
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        chk("ready_wait", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drive_sym(input bit gapped);
        for (int i = 0; i < SYM_LEN; i++) send_one(sym[i], gapped && (i > 0));
    endtask

    // Called right after the last accept: checks the stall and the decision pulse.
    task automatic post_check(input string tag, input int bv0);
        int m1;
        int m2;
        m1 = model(INC_F1);
        m2 = model(INC_F2);
        chk({tag, "_stall_rdy"}, in_ready, 0);
        chk({tag, "_bv_early"}, bit_valid, 0);
        step();
        chk({tag, "_bv"}, bit_valid, 1);
        chk({tag, "_rdy"}, in_ready, 1);
        chk({tag, "_m1"}, metric_f1, m1);
        chk({tag, "_m2"}, metric_f2, m2);
        chk({tag, "_bit"}, bit_out, (m2 > m1) ? 1 : 0);
        prev_m1  = m1;
        prev_m2  = m2;
        prev_bit = (m2 > m1) ? 1 : 0;
        step();
        chk({tag, "_bv_drop"}, bit_valid, 0);
        chk({tag, "_bv_cnt"}, bv_count, bv0 + 1);
    endtask

    task automatic set_f2();
        for (int i = 0; i < SYM_LEN; i++) sym[i] = ((i % 4) < 2) ? 100 : -100;
    endtask

    task automatic set_f1();
        for (int i = 0; i < SYM_LEN; i++) sym[i] = (i < SYM_LEN / 2) ? 100 : -100;
    endtask

    task automatic set_rand();
        for (int i = 0; i < SYM_LEN; i++) sym[i] = int'($urandom_range(2047)) - 1024;
    endtask

    initial begin
        int bv0;

        // Reset held low for three cycles.
        reset = 1'b0;
        step(); step(); step();
        chk("rst_rdy", in_ready, 0);
        chk("rst_bit", bit_out, 0);
        chk("rst_bv", bit_valid, 0);
        chk("rst_m1", metric_f1, 0);
        chk("rst_m2", metric_f2, 0);
        reset = 1'b1;
        step();
        chk("rel_rdy", in_ready, 1);

        // f2 tone, continuous.
        set_f2();
        bv0 = bv_count;
        drive_sym(1'b0);
        post_check("f2", bv0);
        chk("f2_const_m2", metric_f2, 800);

        // f1 tone.
        set_f1();
        bv0 = bv_count;
        drive_sym(1'b0);
        post_check("f1", bv0);
        chk("f1_const_m1", metric_f1, 800);

        // DC gives a tie, which decides 0.
        for (int i = 0; i < SYM_LEN; i++) sym[i] = 100;
        bv0 = bv_count;
        drive_sym(1'b0);
        post_check("dc", bv0);

        // Full-scale f1 pattern.
        for (int i = 0; i < SYM_LEN; i++) sym[i] = (i < SYM_LEN / 2) ? -1024 : 1023;
        bv0 = bv_count;
        drive_sym(1'b0);
        post_check("fs", bv0);
        chk("fs_const_m1", metric_f1, 8188);

        // Gapped f2 tone.
        set_f2();
        bv0 = bv_count;
        drive_sym(1'b1);
        post_check("gap", bv0);

        // Resync after 5 samples, the strobe cycle carries sample 0.
        bv0 = bv_count;
        for (int i = 0; i < 5; i++) send_one(int'($urandom_range(2047)) - 1024, 1'b0);
        set_f1();
        sym_start = 1'b1;
        send_one(sym[0], 1'b0);
        sym_start = 1'b0;
        for (int i = 1; i < SYM_LEN; i++) send_one(sym[i], 1'b0);
        post_check("resync", bv0);

        // Resync during the decision cycle aborts it.
        set_rand();
        bv0 = bv_count;
        drive_sym(1'b0);
        chk("abort_stall_rdy", in_ready, 0);
        sym_start = 1'b1;
        step();
        sym_start = 1'b0;
        chk("abort_bv", bit_valid, 0);
        chk("abort_rdy", in_ready, 1);
        chk("abort_m1_hold", metric_f1, prev_m1);
        chk("abort_m2_hold", metric_f2, prev_m2);
        chk("abort_bit_hold", bit_out, prev_bit);
        step();
        chk("abort_bv_cnt", bv_count, bv0);
        set_f2();
        bv0 = bv_count;
        drive_sym(1'b0);
        post_check("after_abort", bv0);

        // Reset in the middle of a symbol.
        for (int i = 0; i < 3; i++) send_one(500, 1'b0);
        reset = 1'b0;
        step();
        chk("mid_rst_rdy", in_ready, 0);
        chk("mid_rst_m1", metric_f1, 0);
        chk("mid_rst_m2", metric_f2, 0);
        chk("mid_rst_bit", bit_out, 0);
        step();
        reset = 1'b1;
        step();
        chk("mid_rel_rdy", in_ready, 1);
        set_f1();
        bv0 = bv_count;
        drive_sym(1'b0);
        post_check("post_rst", bv0);

        // Random symbols, alternately continuous and gapped.
        for (int r = 0; r < 6; r++) begin
            set_rand();
            bv0 = bv_count;
            drive_sym(r[0]);
            post_check("rand", bv0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
